// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the video/CPU memory arbiter.
package mem_arbiter_pkg;

    localparam int unsigned RAM_SIZE_DEF        = 8192;
    localparam int unsigned XLEN_DEF            = 8;
    localparam int unsigned STALL_CNT_WIDTH_DEF = 16;

    // CPU access FSM: IDLE waits for a grant, DONE returns the completion pulse.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_DONE = 1'b1
    } cpu_state_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Video, CPU and RAM-side signals of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if #(
    parameter int unsigned RAM_ADDR_WIDTH  = 13,
    parameter int unsigned XLEN            = 8,
    parameter int unsigned STALL_CNT_WIDTH = 16
) ();

    logic                       vid_req;
    logic [RAM_ADDR_WIDTH-1:0]  vid_addr;
    logic                       vid_valid;
    logic [XLEN-1:0]            vid_data;

    logic                       cpu_req;
    logic                       cpu_we;
    logic [RAM_ADDR_WIDTH-1:0]  cpu_addr;
    logic [XLEN-1:0]            cpu_wdata;
    logic                       cpu_ready;
    logic [XLEN-1:0]            cpu_rdata;

    logic [RAM_ADDR_WIDTH-1:0]  ram_addr;
    logic                       ram_we;
    logic [XLEN-1:0]            ram_wdata;
    logic [XLEN-1:0]            ram_rdata;

    logic [STALL_CNT_WIDTH-1:0] stall_cnt;

    modport slave (
        input  vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        output vid_valid, vid_data, cpu_ready, cpu_rdata, ram_addr, ram_we, ram_wdata, stall_cnt
    );

    modport master (
        output vid_req, vid_addr, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_rdata,
        input  vid_valid, vid_data, cpu_ready, cpu_rdata, ram_addr, ram_we, ram_wdata, stall_cnt
    );

endinterface

// File: rtl/vid_byte_cache.sv
// One-byte video cache: tag/valid/data, hit compare, miss fill and CPU write-through update.
module vid_byte_cache #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned XLEN       = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  lookup_en,
    input  logic [ADDR_WIDTH-1:0] lookup_addr,
    output logic                  hit_c,
    input  logic                  fill_issue,
    input  logic [XLEN-1:0]       fill_data,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [XLEN-1:0]       wr_data,
    output logic [XLEN-1:0]       cache_data
);

    logic                  valid_q, valid_d;
    logic [ADDR_WIDTH-1:0] tag_q, tag_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  fill_pend_q, fill_pend_d;

    assign hit_c      = lookup_en && valid_q && (lookup_addr == tag_q);
    assign cache_data = data_q;

    // Tag/valid move at miss issue; data lands a cycle later, a CPU write to the tag wins.
    always_comb begin
        valid_d     = valid_q;
        tag_d       = tag_q;
        data_d      = data_q;
        fill_pend_d = fill_issue;
        if (fill_pend_q) begin
            data_d = fill_data;
        end
        if (wr_en && valid_q && (wr_addr == tag_q)) begin
            data_d = wr_data;
        end
        if (fill_issue) begin
            tag_d   = lookup_addr;
            valid_d = 1'b1;
        end
    end

    // Cache state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            tag_q       <= '0;
            data_q      <= '0;
            fill_pend_q <= 1'b0;
        end else begin
            valid_q     <= valid_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            fill_pend_q <= fill_pend_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port RAM arbiter: video has absolute priority through a one-byte cache,
// the CPU is served by a two-state FSM and blocked cycles are counted.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned RAM_SIZE        = RAM_SIZE_DEF,
    parameter int unsigned RAM_ADDR_WIDTH  = $clog2(RAM_SIZE),
    parameter int unsigned XLEN            = XLEN_DEF,
    parameter int unsigned STALL_CNT_WIDTH = STALL_CNT_WIDTH_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    mem_arbiter_if.slave bus
);

    cpu_state_e                 state_q, state_d;
    logic                       vid_valid_q, vid_valid_d;
    logic                       vid_from_ram_q, vid_from_ram_d;
    logic                       cpu_we_q, cpu_we_d;
    logic [XLEN-1:0]            cpu_wdata_q, cpu_wdata_d;
    logic [STALL_CNT_WIDTH-1:0] stall_q, stall_d;

    logic                       vid_hit_c;
    logic                       vid_miss_c;
    logic                       cpu_grant_c;
    logic                       cpu_wr_c;
    logic [XLEN-1:0]            cache_data;

    vid_byte_cache #(
        .ADDR_WIDTH (RAM_ADDR_WIDTH),
        .XLEN       (XLEN)
    ) u_vid_byte_cache (
        .clk         (clk),
        .rst_n       (rst_n),
        .lookup_en   (bus.vid_req),
        .lookup_addr (bus.vid_addr),
        .hit_c       (vid_hit_c),
        .fill_issue  (vid_miss_c),
        .fill_data   (bus.ram_rdata),
        .wr_en       (cpu_wr_c),
        .wr_addr     (bus.cpu_addr),
        .wr_data     (bus.cpu_wdata),
        .cache_data  (cache_data)
    );

    // Arbitration and RAM port drive; nothing is issued while reset is asserted.
    always_comb begin
        vid_miss_c    = rst_n && bus.vid_req && !vid_hit_c;
        cpu_grant_c   = rst_n && (state_q == ST_IDLE) && bus.cpu_req && !vid_miss_c;
        cpu_wr_c      = cpu_grant_c && bus.cpu_we;
        bus.ram_addr  = '0;
        bus.ram_we    = 1'b0;
        bus.ram_wdata = '0;
        if (vid_miss_c) begin
            bus.ram_addr = bus.vid_addr;
        end else if (cpu_grant_c) begin
            bus.ram_addr  = bus.cpu_addr;
            bus.ram_we    = bus.cpu_we;
            bus.ram_wdata = bus.cpu_wdata;
        end
    end

    // CPU FSM next state, video return tracking and saturating stall counter.
    always_comb begin
        state_d        = state_q;
        vid_valid_d    = bus.vid_req;
        vid_from_ram_d = vid_miss_c;
        cpu_we_d       = cpu_we_q;
        cpu_wdata_d    = cpu_wdata_q;
        stall_d        = stall_q;
        case (state_q)
            ST_IDLE: begin
                if (cpu_grant_c) begin
                    state_d     = ST_DONE;
                    cpu_we_d    = bus.cpu_we;
                    cpu_wdata_d = bus.cpu_wdata;
                end else if (bus.cpu_req && vid_miss_c && (stall_q != '1)) begin
                    stall_d = stall_q + STALL_CNT_WIDTH'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            vid_valid_q    <= 1'b0;
            vid_from_ram_q <= 1'b0;
            cpu_we_q       <= 1'b0;
            cpu_wdata_q    <= '0;
            stall_q        <= '0;
        end else begin
            state_q        <= state_d;
            vid_valid_q    <= vid_valid_d;
            vid_from_ram_q <= vid_from_ram_d;
            cpu_we_q       <= cpu_we_d;
            cpu_wdata_q    <= cpu_wdata_d;
            stall_q        <= stall_d;
        end
    end

    // Return data is steered from the RAM in the cycle its synchronous read completes.
    always_comb begin
        bus.vid_valid = vid_valid_q;
        bus.vid_data  = '0;
        if (vid_valid_q) begin
            bus.vid_data = vid_from_ram_q ? bus.ram_rdata : cache_data;
        end
        bus.cpu_ready = (state_q == ST_DONE);
        bus.cpu_rdata = '0;
        if (state_q == ST_DONE) begin
            bus.cpu_rdata = cpu_we_q ? cpu_wdata_q : bus.ram_rdata;
        end
        bus.stall_cnt = stall_q;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus randomized traffic against a
// memory-level reference model (reads see the latest committed write).
module tb_mem_arbiter;

    localparam int unsigned RAM_SIZE = 16384;
    localparam int unsigned AW       = 14;
    localparam int unsigned XLEN     = 8;
    localparam int unsigned SW       = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_arbiter_if #(.RAM_ADDR_WIDTH(AW), .XLEN(XLEN), .STALL_CNT_WIDTH(SW)) bus ();

    mem_arbiter #(
        .RAM_SIZE        (RAM_SIZE),
        .RAM_ADDR_WIDTH  (AW),
        .XLEN            (XLEN),
        .STALL_CNT_WIDTH (SW)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Power-up memory contents, known to both the RAM and the model.
    function automatic logic [7:0] init_byte(input logic [AW-1:0] a);
        if (a == 14'h0400) return 8'hA5;
        if (a == 14'h2000) return 8'h3C;
        return 8'(a[7:0] ^ a[13:6] ^ 8'h5C);
    endfunction

    // Synchronous RAM, one-cycle read latency.
    logic [7:0] ram_mem [RAM_SIZE];
    initial begin
        for (int i = 0; i < int'(RAM_SIZE); i++) ram_mem[i] = init_byte(AW'(i));
        forever begin
            @(posedge clk);
            if (bus.ram_we) ram_mem[bus.ram_addr] <= bus.ram_wdata;
            bus.ram_rdata <= ram_mem[bus.ram_addr];
        end
    end

    // Reference model: memory image plus the video unit's last fetched address.
    logic [7:0]    golden  [RAM_SIZE];
    bit            written [RAM_SIZE];
    bit            m_busy  = 1'b0;
    bit            m_have  = 1'b0;
    logic [AW-1:0] m_last  = '0;
    logic          e_vv    = 1'b0;
    logic [7:0]    e_vd    = '0;
    logic          e_rdy   = 1'b0;
    logic [7:0]    e_rd    = '0;
    logic [SW-1:0] e_stall = '0;

    function automatic logic [7:0] g_read(input logic [AW-1:0] a);
        return written[a] ? golden[a] : init_byte(a);
    endfunction

    function automatic logic m_miss();
        return bus.vid_req && !(m_have && (bus.vid_addr == m_last));
    endfunction

    function automatic logic m_grant();
        return bus.cpu_req && !m_busy && !m_miss();
    endfunction

    function automatic logic [7:0] m_vid_value();
        if (m_grant() && bus.cpu_we && (bus.cpu_addr == bus.vid_addr)) return bus.cpu_wdata;
        return g_read(bus.vid_addr);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  <= 1'b0;
            m_have  <= 1'b0;
            m_last  <= '0;
            e_vv    <= 1'b0;
            e_vd    <= '0;
            e_rdy   <= 1'b0;
            e_rd    <= '0;
            e_stall <= '0;
        end else begin
            if (m_grant() && bus.cpu_we) begin
                golden[bus.cpu_addr]  <= bus.cpu_wdata;
                written[bus.cpu_addr] <= 1'b1;
            end
            e_rdy <= m_grant();
            e_rd  <= m_grant() ? (bus.cpu_we ? bus.cpu_wdata : g_read(bus.cpu_addr)) : 8'h00;
            if (bus.cpu_req && !m_busy && m_miss() && (e_stall != '1)) e_stall <= e_stall + SW'(1);
            m_busy <= m_grant();
            e_vv   <= bus.vid_req;
            e_vd   <= bus.vid_req ? m_vid_value() : 8'h00;
            if (bus.vid_req) begin
                m_have <= 1'b1;
                m_last <= bus.vid_addr;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_cycle();
        logic [AW-1:0] ea;
        logic          ew;
        logic [7:0]    ewd;
        ea  = '0;
        ew  = 1'b0;
        ewd = '0;
        if (rst_n) begin
            if (m_miss()) begin
                ea = bus.vid_addr;
            end else if (m_grant()) begin
                ea  = bus.cpu_addr;
                ew  = bus.cpu_we;
                ewd = bus.cpu_wdata;
            end
        end
        check("ram_addr",  32'(bus.ram_addr),  32'(ea));
        check("ram_we",    32'(bus.ram_we),    32'(ew));
        check("ram_wdata", 32'(bus.ram_wdata), 32'(ewd));
        check("vid_valid", 32'(bus.vid_valid), 32'(e_vv));
        check("vid_data",  32'(bus.vid_data),  32'(e_vd));
        check("cpu_ready", 32'(bus.cpu_ready), 32'(e_rdy));
        check("cpu_rdata", 32'(bus.cpu_rdata), 32'(e_rd));
        check("stall_cnt", 32'(bus.stall_cnt), 32'(e_stall));
    endtask

    always @(negedge clk) compare_cycle();

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [AW-1:0] pick_addr();
        case ($urandom_range(0, 7))
            0: return 14'h0400;
            1: return 14'h0401;
            2: return 14'h0402;
            3: return 14'h2000;
            4: return 14'h3FFF;
            5: return 14'h0000;
            default: return AW'($urandom_range(0, RAM_SIZE - 1));
        endcase
    endfunction

    initial begin
        bit cpu_pend;
        bus.vid_req   = 1'b0;
        bus.vid_addr  = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;

        // Reset state.
        repeat (3) tick();
        check("d_rst_vid_valid", 32'(bus.vid_valid), 32'd0);
        check("d_rst_vid_data",  32'(bus.vid_data),  32'd0);
        check("d_rst_cpu_ready", 32'(bus.cpu_ready), 32'd0);
        check("d_rst_cpu_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("d_rst_stall",     32'(bus.stall_cnt), 32'd0);
        rst_n = 1'b1;

        // Video miss at 0x400, then a hit while the CPU reads 0x2000.
        tick();
        bus.vid_req = 1'b1; bus.vid_addr = 14'h0400; #1;
        check("d_miss_ram_addr", 32'(bus.ram_addr), 32'h400);
        check("d_miss_ram_we",   32'(bus.ram_we),   32'd0);
        tick();
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h2000; #1;
        check("d_miss_vid_valid", 32'(bus.vid_valid), 32'd1);
        check("d_miss_vid_data",  32'(bus.vid_data),  32'hA5);
        check("d_hit_cpu_grant",  32'(bus.ram_addr),  32'h2000);
        tick();
        bus.vid_req = 1'b0; bus.cpu_req = 1'b0; #1;
        check("d_hit_vid_data",  32'(bus.vid_data),  32'hA5);
        check("d_hit_cpu_ready", 32'(bus.cpu_ready), 32'd1);
        check("d_hit_cpu_rdata", 32'(bus.cpu_rdata), 32'h3C);

        // CPU read blocked by three consecutive video misses.
        tick();
        bus.cpu_req = 1'b1; bus.cpu_addr = 14'h2000;
        bus.vid_req = 1'b1; bus.vid_addr = 14'h0100;
        tick(); bus.vid_addr = 14'h0101;
        tick(); bus.vid_addr = 14'h0102;
        tick(); bus.vid_req = 1'b0; #1;
        check("d_stall_cnt",   32'(bus.stall_cnt), 32'd3);
        check("d_stall_grant", 32'(bus.ram_addr),  32'h2000);
        tick(); bus.cpu_req = 1'b0; #1;
        check("d_stall_ready", 32'(bus.cpu_ready), 32'd1);
        check("d_stall_rdata", 32'(bus.cpu_rdata), 32'h3C);

        // CPU write to the cached address keeps the video byte coherent.
        tick(); bus.vid_req = 1'b1; bus.vid_addr = 14'h0400;
        tick(); bus.vid_req = 1'b0;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 14'h0400; bus.cpu_wdata = 8'h5A; #1;
        check("d_wr_ram_we",    32'(bus.ram_we),    32'd1);
        check("d_wr_ram_addr",  32'(bus.ram_addr),  32'h400);
        check("d_wr_ram_wdata", 32'(bus.ram_wdata), 32'h5A);
        tick(); bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; #1;
        check("d_wr_ready",   32'(bus.cpu_ready), 32'd1);
        check("d_wr_we_once", 32'(bus.ram_we),    32'd0);
        tick(); bus.vid_req = 1'b1; bus.vid_addr = 14'h0400; #1;
        check("d_wr_hit_ram_idle", 32'(bus.ram_addr), 32'd0);
        tick(); bus.vid_req = 1'b0; #1;
        check("d_wr_hit_valid", 32'(bus.vid_valid), 32'd1);
        check("d_wr_hit_data",  32'(bus.vid_data),  32'h5A);

        // Stall counter saturates at all-ones and holds.
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 14'h2000;
        for (int i = 0; i < 35; i++) begin
            tick();
            bus.vid_req  = 1'b1;
            bus.vid_addr = (i % 2 == 1) ? 14'h0010 : 14'h0011;
        end
        tick(); #1;
        check("d_sat_cnt", 32'(bus.stall_cnt), 32'd31);
        bus.vid_addr = 14'h0012;
        tick(); #1;
        check("d_sat_hold", 32'(bus.stall_cnt), 32'd31);

        // Held CPU request completes every second cycle.
        bus.vid_req = 1'b0;
        for (int i = 1; i <= 7; i++) begin
            tick(); #1;
            check("d_tput_ready", 32'(bus.cpu_ready), 32'(i % 2));
        end

        // Reset asserted during DONE drops the access at once.
        rst_n = 1'b0; bus.cpu_req = 1'b0; #1;
        check("d_mid_rst_ready", 32'(bus.cpu_ready), 32'd0);
        check("d_mid_rst_rdata", 32'(bus.cpu_rdata), 32'd0);
        check("d_mid_rst_vv",    32'(bus.vid_valid), 32'd0);
        check("d_mid_rst_stall", 32'(bus.stall_cnt), 32'd0);
        check("d_mid_rst_we",    32'(bus.ram_we),    32'd0);
        tick(); tick();
        rst_n = 1'b1; #1;
        check("d_post_rst_we",    32'(bus.ram_we),    32'd0);
        check("d_post_rst_ready", 32'(bus.cpu_ready), 32'd0);
        tick(); #1;
        check("d_post_rst_we2",    32'(bus.ram_we),    32'd0);
        check("d_post_rst_ready2", 32'(bus.cpu_ready), 32'd0);

        // Randomized traffic, CPU obeys hold-until-ready, occasional mid-cycle reset.
        cpu_pend = 1'b0;
        for (int n = 0; n < 4000; n++) begin
            tick();
            if ($urandom_range(0, 499) == 0) begin
                rst_n = 1'b0;
                bus.cpu_req = 1'b0;
                cpu_pend = 1'b0;
                tick();
                rst_n = 1'b1;
            end
            if (cpu_pend && bus.cpu_ready) begin
                cpu_pend    = 1'b0;
                bus.cpu_req = 1'b0;
            end
            if (!cpu_pend && ($urandom_range(0, 9) < 6)) begin
                cpu_pend      = 1'b1;
                bus.cpu_req   = 1'b1;
                bus.cpu_we    = 1'($urandom_range(0, 1));
                bus.cpu_addr  = pick_addr();
                bus.cpu_wdata = 8'($urandom);
            end
            bus.vid_req  = 1'($urandom_range(0, 1));
            bus.vid_addr = pick_addr();
        end
        tick();
        bus.vid_req = 1'b0;
        bus.cpu_req = 1'b0;
        repeat (3) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
